// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains an 8-bit FIFO and packs bytes little-endian into words; define PACKER_FLUSH_EN to flush idle partial words
module fifo_word_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int FLUSH_TIMEOUT  = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fifo_empty,
  input  logic [7:0]                    fifo_data,
  output logic                          fifo_rd_en,
  output logic [8*BYTES_PER_WORD-1:0]   m_data,
  output logic [BYTES_PER_WORD-1:0]     m_keep,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          busy
);
  localparam int N  = BYTES_PER_WORD;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [CW:0]   C_N    = (CW + 1)'(N);
  typedef enum logic {FILL, HOLD} state_t;
  state_t r_state, w_state_nxt;
  logic [8*N-1:0] r_pack, r_m_data;
  logic [CW-1:0]  r_cnt;
  logic           r_pend, r_m_valid, w_load, w_flush;
  if (N < 2 || N > 8) $error("BYTES_PER_WORD must be 2..8");
  if (FLUSH_TIMEOUT < 2 || FLUSH_TIMEOUT > 255) $error("FLUSH_TIMEOUT must be 2..255");
  assign fifo_rd_en = rst_n && !fifo_empty && r_state == FILL && ({1'b0, r_cnt} + {{CW{1'b0}}, r_pend}) < C_N;
  assign busy       = r_cnt != '0 || r_pend || r_m_valid;
  assign m_data     = r_m_data;
  assign m_valid    = r_m_valid;
`ifdef PACKER_FLUSH_EN
  logic [7:0]   r_idle;
  logic [N-1:0] r_m_keep, w_keep;
  logic         w_idle_inc;
  assign w_idle_inc = r_state == FILL && r_cnt != '0 && !r_pend && !fifo_rd_en;
  assign w_flush    = w_idle_inc && r_idle == 8'(FLUSH_TIMEOUT - 1);
  assign m_keep     = r_m_keep;
  // keep mask covers only the lanes captured so far
  always_comb begin
    w_keep = '0;
    for (int i = 0; i < N; i++) w_keep[i] = CW'(i) < r_cnt;
  end
  // idle counter: stalled cycles of a partial word, cleared by reads, empty pack or HOLD
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_idle <= '0;
    else r_idle <= (fifo_rd_en || r_cnt == '0 || w_state_nxt == HOLD) ? '0 : w_idle_inc ? r_idle + 8'd1 : r_idle;
  // keep mask travels with the word into the output register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_m_keep <= '0;
    else if (w_load) r_m_keep <= w_keep;
`else
  assign w_flush = 1'b0;
  assign m_keep  = '1;
`endif
  // next state: fill until a word completes (or flushes), hold until the output register frees
  always_comb begin
    w_load      = r_state == HOLD && (!r_m_valid || m_ready);
    w_state_nxt = r_state;
    if (r_state == FILL && ((r_pend && r_cnt == C_LAST) || w_flush)) w_state_nxt = HOLD;
    if (w_load) w_state_nxt = FILL;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= FILL;
    else r_state <= w_state_nxt;
  // pending read tracking and byte capture into the pack register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pend <= 1'b0;
      r_cnt  <= '0;
      r_pack <= '0;
    end else begin
      r_pend <= fifo_rd_en;
      if (w_load) begin
        r_cnt  <= '0;
        r_pack <= '0;
      end else if (r_pend) begin
        for (int i = 0; i < N; i++) if (r_cnt == CW'(i)) r_pack[8*i +: 8] <= fifo_data;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  // output register: load on HOLD exit, otherwise drop valid once accepted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
    end else if (w_load) begin
      r_m_data  <= r_pack;
      r_m_valid <= 1'b1;
    end else if (r_m_valid && m_ready) r_m_valid <= 1'b0;
endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer: scoreboard bench for fifo_word_packer with a byte-FIFO model
module tb_fifo_word_packer;
  localparam int N = 4;
  logic        clk = 1'b0, rst_n = 1'b0, m_ready = 1'b0;
  logic        fifo_empty, fifo_rd_en, m_valid, busy;
  logic [7:0]  fifo_data = 8'h00;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic [7:0]  mem [0:63];
  int          rd_cyc [0:63];
  int          wr_ptr = 0, rd_ptr = 0, cyc = 0, base = 0;
  int          vectors = 0, miscompares = 0;
  logic [35:0] exp_q [$];
  bit          ok, stable;

  always #5 clk = ~clk;
  assign fifo_empty = (wr_ptr == rd_ptr);

  fifo_word_packer #(.BYTES_PER_WORD(N), .FLUSH_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy));

  // FIFO model: registered data_out one cycle after an accepted read
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= mem[rd_ptr[5:0]];
      rd_cyc[rd_ptr[5:0]] <= cyc;
      rd_ptr <= rd_ptr + 1;
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[5:0]] = b;
    wr_ptr++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int maxc, output bit got);
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge clk);
      got = m_valid;
    end
  endtask

  task automatic wait_idle(input int maxc, output bit got);
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge clk);
      got = !busy && fifo_empty;
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst_n && m_valid && m_ready) begin
          if (exp_q.size() == 0) chk("unexpected_word", {32'h0, m_data}, 64'hDEAD);
          else begin
            logic [35:0] e;
            e = exp_q.pop_front();
            chk("word_data", {32'h0, m_data}, {32'h0, e[31:0]});
            chk("word_keep", {60'h0, m_keep}, {60'h0, e[35:32]});
          end
        end
      end
    join_none
    push(8'h11);
    tick(2);
    @(negedge clk);
    chk("reset_rd_en", fifo_rd_en, 0);
    chk("reset_valid", m_valid, 0);
    chk("reset_busy", busy, 0);
`ifdef PACKER_FLUSH_EN
    chk("reset_keep", m_keep, 4'h0);
`else
    chk("reset_keep", m_keep, 4'hF);
`endif
    tick(1);
    rst_n = 1'b1;
    m_ready = 1'b1;
    exp_q.push_back({4'hF, 32'h44332211});
    exp_q.push_back({4'hF, 32'h88776655});
    push(8'h22); push(8'h33); push(8'h44);
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    wait_valid(30, ok);
    chk("first_word_seen", ok, 1);
    chk("latency", cyc - rd_cyc[3], 3);
    wait_idle(60, ok);
    chk("drain_1", ok, 1);
    tick(1);
    m_ready = 1'b0;
    base = rd_ptr;
    for (int i = 1; i <= 12; i++) push(8'(i));
    exp_q.push_back({4'hF, 32'h04030201});
    exp_q.push_back({4'hF, 32'h08070605});
    exp_q.push_back({4'hF, 32'h0C0B0A09});
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (m_valid && m_data !== 32'h04030201) stable = 1'b0;
    end
    chk("bp_valid", m_valid, 1);
    chk("bp_hold_data", m_data, 32'h04030201);
    chk("bp_stable", stable, 1);
    chk("bp_reads", rd_ptr - base, 8);
    chk("bp_rd_en_low", fifo_rd_en, 0);
    tick(1);
    m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("handoff_valid", m_valid, 1);
    chk("handoff_data", m_data, 32'h08070605);
    wait_idle(60, ok);
    chk("drain_2", ok, 1);
    tick(1);
    push(8'hE1); push(8'hE2);
    tick(5);
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_rd_en", fifo_rd_en, 0);
    tick(2);
    rst_n = 1'b1;
    exp_q.push_back({4'hF, 32'hA4A3A2A1});
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    wait_valid(30, ok);
    chk("post_reset_word_seen", ok, 1);
    wait_idle(60, ok);
    chk("drain_3", ok, 1);
    tick(1);
    push(8'hAA); push(8'hBB); push(8'hCC);
`ifdef PACKER_FLUSH_EN
    exp_q.push_back({4'b0111, 32'h00CCBBAA});
    wait_valid(40, ok);
    chk("flush_seen", ok, 1);
    wait_idle(20, ok);
    chk("drain_flush", ok, 1);
`else
    wait_valid(100, ok);
    chk("no_flush", ok, 0);
    chk("partial_busy", busy, 1);
`endif
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
